alu_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one registered ALU (`my_alu`, 1-cycle operand-to-result latency) between two independent requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block drives the ALU operand and opcode inputs, tracks the single in-flight operation, and steers the ALU outputs into a 1-entry response buffer per requester. It sits between the ALU and its clients, and the ALU instance lives outside this block.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 12 +
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice.
package alu_pkg;

  localparam int unsigned NUMBITS = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDS = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SUBS = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  localparam int unsigned IdW = 1;
  typedef logic [IdW-1:0] req_id_t;

  typedef enum logic {StIdle, StInflight} infl_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant history is owned by the caller.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // On a tie the requester that did not win last time goes first.
  assign grant_o[0] = req_i[0] && (!req_i[1] || last_grant_i);
  assign grant_o[1] = req_i[1] && (!req_i[0] || !last_grant_i);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters, one op in flight,
// with a one-entry response buffer per requester.
module alu_arbiter #(
  parameter int unsigned NUMBITS = alu_pkg::NUMBITS
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [NUMBITS-1:0] req0_a_i,
  input  logic [NUMBITS-1:0] req0_b_i,
  input  logic [2:0]         req0_opcode_i,

  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [NUMBITS-1:0] req1_a_i,
  input  logic [NUMBITS-1:0] req1_b_i,
  input  logic [2:0]         req1_opcode_i,

  output logic               rsp0_valid_o,
  input  logic               rsp0_ready_i,
  output logic [NUMBITS-1:0] rsp0_result_o,
  output logic               rsp0_carryout_o,
  output logic               rsp0_overflow_o,
  output logic               rsp0_zero_o,

  output logic               rsp1_valid_o,
  input  logic               rsp1_ready_i,
  output logic [NUMBITS-1:0] rsp1_result_o,
  output logic               rsp1_carryout_o,
  output logic               rsp1_overflow_o,
  output logic               rsp1_zero_o,

  output logic [NUMBITS-1:0] alu_a_o,
  output logic [NUMBITS-1:0] alu_b_o,
  output logic [2:0]         alu_opcode_o,
  input  logic [NUMBITS-1:0] alu_result_i,
  input  logic               alu_carryout_i,
  input  logic               alu_overflow_i,
  input  logic               alu_zero_i,

  output logic               busy_o
);

  import alu_pkg::*;

  infl_st_e           infl_q;
  req_id_t            infl_id_q;
  logic               last_grant_q;
  logic [1:0]         rsp_valid_q;
  logic [NUMBITS-1:0] rsp_result_q [2];
  logic [1:0]         rsp_carry_q;
  logic [1:0]         rsp_ovf_q;
  logic [1:0]         rsp_zero_q;

  logic [1:0] req_valid, rsp_ready, elig, req, ready, grant;
  logic       inflight;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign inflight  = (infl_q == StInflight);

  // Eligibility uses registered buffer state, so a pop only frees the requester next cycle.
  assign elig[0] = !reset && !rsp_valid_q[0] && !(inflight && infl_id_q == 1'b0);
  assign elig[1] = !reset && !rsp_valid_q[1] && !(inflight && infl_id_q == 1'b1);
  assign req     = req_valid & elig;

  assign ready[0] = elig[0] && (!req[1] || last_grant_q);
  assign ready[1] = elig[1] && (!req[0] || !last_grant_q);

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_opcode_o = OP_ADD;
    unique case (grant)
      2'b01: begin
        alu_a_o      = req0_a_i;
        alu_b_o      = req0_b_i;
        alu_opcode_o = req0_opcode_i;
      end
      2'b10: begin
        alu_a_o      = req1_a_i;
        alu_b_o      = req1_b_i;
        alu_opcode_o = req1_opcode_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      infl_q          <= StIdle;
      infl_id_q       <= '0;
      last_grant_q    <= 1'b1;
      rsp_valid_q     <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
      rsp_carry_q     <= '0;
      rsp_ovf_q       <= '0;
      rsp_zero_q      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid_q[i] && rsp_ready[i]) rsp_valid_q[i] <= 1'b0;
      end
      // The target buffer is always empty here: its owner was ineligible while in flight.
      if (inflight) begin
        rsp_valid_q[infl_id_q]  <= 1'b1;
        rsp_result_q[infl_id_q] <= alu_result_i;
        rsp_carry_q[infl_id_q]  <= alu_carryout_i;
        rsp_ovf_q[infl_id_q]    <= alu_overflow_i;
        rsp_zero_q[infl_id_q]   <= alu_zero_i;
      end
      if (|grant) begin
        infl_q       <= StInflight;
        infl_id_q    <= grant[1];
        last_grant_q <= grant[1];
      end else begin
        infl_q <= StIdle;
      end
    end
  end

  assign req0_ready_o    = ready[0];
  assign req1_ready_o    = ready[1];
  assign busy_o          = !reset && inflight;
  assign rsp0_valid_o    = !reset && rsp_valid_q[0];
  assign rsp1_valid_o    = !reset && rsp_valid_q[1];
  assign rsp0_result_o   = reset ? '0 : rsp_result_q[0];
  assign rsp1_result_o   = reset ? '0 : rsp_result_q[1];
  assign rsp0_carryout_o = !reset && rsp_carry_q[0];
  assign rsp1_carryout_o = !reset && rsp_carry_q[1];
  assign rsp0_overflow_o = !reset && rsp_ovf_q[0];
  assign rsp1_overflow_o = !reset && rsp_ovf_q[1];
  assign rsp0_zero_o     = !reset && rsp_zero_q[0];
  assign rsp1_zero_o     = !reset && rsp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU and a response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_opcode, req1_opcode;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_carryout, rsp0_overflow, rsp0_zero;
  logic         rsp1_carryout, rsp1_overflow, rsp1_zero;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_opcode;
  logic         alu_carryout, alu_overflow, alu_zero;
  logic         busy;
  logic         stub_on = 1'b0;

  int total = 0;
  int bad = 0;

  // Packed as {carry, overflow, zero, result}.
  function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      OP_ADD, OP_ADDS: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB, OP_SUBS: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a << b[4:0];
    endcase
    return {c, v, (r == '0), r};
  endfunction

  function automatic logic [W+2:0] exp_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W+2:0] e;
    e = alu_fn(a, b, op);
    if (stub_on) begin
      e[W+1] = 1'b1;
      e[W]   = 1'b0;
    end
    return e;
  endfunction

  logic [W+2:0] alu_q;
  always_ff @(posedge clk) alu_q <= alu_fn(alu_a, alu_b, alu_opcode);
  assign alu_result   = alu_q[W-1:0];
  assign alu_zero     = stub_on ? 1'b0 : alu_q[W];
  assign alu_overflow = stub_on ? 1'b1 : alu_q[W+1];
  assign alu_carryout = alu_q[W+2];

  alu_arbiter #(.NUMBITS(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid_i    (req0_valid),
    .req0_ready_o    (req0_ready),
    .req0_a_i        (req0_a),
    .req0_b_i        (req0_b),
    .req0_opcode_i   (req0_opcode),
    .req1_valid_i    (req1_valid),
    .req1_ready_o    (req1_ready),
    .req1_a_i        (req1_a),
    .req1_b_i        (req1_b),
    .req1_opcode_i   (req1_opcode),
    .rsp0_valid_o    (rsp0_valid),
    .rsp0_ready_i    (rsp0_ready),
    .rsp0_result_o   (rsp0_result),
    .rsp0_carryout_o (rsp0_carryout),
    .rsp0_overflow_o (rsp0_overflow),
    .rsp0_zero_o     (rsp0_zero),
    .rsp1_valid_o    (rsp1_valid),
    .rsp1_ready_i    (rsp1_ready),
    .rsp1_result_o   (rsp1_result),
    .rsp1_carryout_o (rsp1_carryout),
    .rsp1_overflow_o (rsp1_overflow),
    .rsp1_zero_o     (rsp1_zero),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_opcode_o    (alu_opcode),
    .alu_result_i    (alu_result),
    .alu_carryout_i  (alu_carryout),
    .alu_overflow_i  (alu_overflow),
    .alu_zero_i      (alu_zero),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  logic [W+2:0] q0[$];
  logic [W+2:0] q1[$];
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req0_valid && req0_ready) q0.push_back(exp_fn(req0_a, req0_b, req0_opcode));
      if (req1_valid && req1_ready) q1.push_back(exp_fn(req1_a, req1_b, req1_opcode));
      if (rsp0_valid && rsp0_ready) begin
        chk("sb_rsp0_expected", 64'(q0.size() > 0), 64'(1));
        if (q0.size() > 0)
          chk("sb_rsp0", 64'({rsp0_carryout, rsp0_overflow, rsp0_zero, rsp0_result}),
              64'(q0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        chk("sb_rsp1_expected", 64'(q1.size() > 0), 64'(1));
        if (q1.size() > 0)
          chk("sb_rsp1", 64'({rsp1_carryout, rsp1_overflow, rsp1_zero, rsp1_result}),
              64'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] pat [9];
  logic [1:0] g;
  int         n1;
  logic       got;
  logic       hs;

  initial begin
    pat = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    // Requests held during reset must not be accepted.
    req0_valid = 1'b1; req0_a = 32'd5;  req0_b = 32'd3;  req0_opcode = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd9;  req1_b = 32'd1;  req1_opcode = OP_SUB;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
    chk("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_alu", 64'({alu_opcode, alu_a, alu_b} != '0), 64'(0));
    chk("rst_rsp_data", 64'({rsp0_result, rsp1_result, rsp0_carryout, rsp0_overflow,
                             rsp0_zero, rsp1_carryout, rsp1_overflow, rsp1_zero} != '0), 64'(0));
    tick();
    reset = 1'b0;
    req1_valid = 1'b0;

    // Single request 5+3.
    @(negedge clk);
    chk("t1_ready", 64'(req0_ready), 64'(1));
    chk("t1_alu_a", 64'(alu_a), 64'(5));
    chk("t1_alu_b", 64'(alu_b), 64'(3));
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy_t1", 64'(busy), 64'(1));
    chk("t1_no_rsp_t1", 64'(rsp0_valid), 64'(0));
    chk("t1_alu_idle", 64'(alu_a), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp0_valid), 64'(1));
    chk("t1_result", 64'(rsp0_result), 64'(8));
    chk("t1_flags", 64'({rsp0_carryout, rsp0_zero}), 64'(0));
    chk("t1_busy_t2", 64'(busy), 64'(0));
    tick();

    // Tie after reset: req0 first.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;   req0_opcode = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'hF0;        req1_b = 32'h0F;  req1_opcode = OP_XOR;
    @(negedge clk);
    chk("t2_tie", 64'({req1_ready, req0_ready}), 64'(2'b01));
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t2_req1_t1", 64'(req1_ready), 64'(1));
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp0_valid", 64'({rsp1_valid, rsp0_valid}), 64'(2'b01));
    chk("t2_rsp0", 64'({rsp0_carryout, rsp0_zero, rsp0_result}), 64'({2'b11, 32'd0}));
    tick();
    @(negedge clk);
    chk("t2_rsp1_valid", 64'(rsp1_valid), 64'(1));
    chk("t2_rsp1_result", 64'(rsp1_result), 64'(32'hFF));
    tick();

    // Backpressure on rsp0 while req1 keeps flowing.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_opcode = OP_SUB;
    @(negedge clk);
    chk("t3_req0_grant", 64'(req0_ready), 64'(1));
    tick();
    req0_a = 32'hA; req0_b = 32'h5; req0_opcode = OP_OR;
    @(negedge clk);
    chk("t3_req0_inflight", 64'(req0_ready), 64'(0));
    tick();
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_opcode = OP_ADD;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_req0_blocked", 64'(req0_ready), 64'(0));
      chk("t3_rsp0_stable", 64'({rsp0_valid, rsp0_result}), 64'({1'b1, 32'd7}));
      hs = req1_valid && req1_ready;
      if (hs) n1++;
      tick();
      if (hs) req1_a = req1_a + 32'd1;
    end
    chk("t3_req1_grants", 64'(n1), 64'(4));
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req0_ready;
      tick();
    end
    chk("t3_req0_resumes", 64'(got), 64'(1));
    req0_valid = 1'b0;
    repeat (4) tick();

    // Fairness with both requesters saturating.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_opcode = OP_SHL;
    req1_valid = 1'b1; req1_a = 32'hC; req1_b = 32'hA; req1_opcode = OP_AND;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      g = {req1_valid && req1_ready, req0_valid && req0_ready};
      chk("t4_grant", 64'(g), 64'(pat[i]));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) tick();

    // Flag pass-through with a stubbed ALU.
    stub_on = 1'b1;
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_opcode = OP_ADDS;
    @(negedge clk);
    chk("t5_grant", 64'(req1_ready), 64'(1));
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5_rsp1_valid", 64'(rsp1_valid), 64'(1));
    chk("t5_flags", 64'({rsp1_overflow, rsp1_zero}), 64'(2'b10));
    chk("t5_result", 64'(rsp1_result), 64'(32'h8000_0000));
    tick();
    stub_on = 1'b0;

    // Reset one cycle after a grant discards the operation.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_opcode = OP_ADD;
    @(negedge clk);
    chk("t6_grant", 64'(req0_ready), 64'(1));
    tick();
    reset = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_opcode = OP_OR;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_ready_in_rst", 64'({req1_ready, req0_ready}), 64'(0));
      chk("t6_busy_in_rst", 64'(busy), 64'(0));
      tick();
    end
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_stale_rsp", 64'({rsp1_valid, rsp0_valid}), 64'(0));
      tick();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_tie_after_rst", 64'({req1_ready, req0_ready}), 64'(2'b01));
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t6_req1_next", 64'(req1_ready), 64'(1));
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();

    @(negedge clk);
    chk("sb_drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
